// File: rtl/pipeline_result_fifo_if.sv
// Handshake bundle between the result FIFO and its producer/consumer side.
// The testbench or surrounding logic drives the master side; the FIFO is the slave.
interface pipeline_result_fifo_if #(
  parameter int n  = 10,
  parameter int AW = 2
);
  logic         in_valid;
  logic [n-1:0] f_in;
  logic [n-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [AW:0]  count;
  logic         full;
  logic         overflow;
  logic         ovf_clr;

  modport master (
    output in_valid, f_in, out_ready, ovf_clr,
    input  out_data, out_valid, count, full, overflow
  );

  modport slave (
    input  in_valid, f_in, out_ready, ovf_clr,
    output out_data, out_valid, count, full, overflow
  );
endinterface

// File: rtl/pipeline_result_fifo.sv
// Re-aligns the upstream pipeline's issue strobe to its f output and buffers results in a FIFO.
// Optional PIPE_RES_STATS_EN adds saturating accepted/dropped result counters.
module pipeline_result_fifo #(
  parameter int n     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_result_fifo_if.slave bus
`ifdef PIPE_RES_STATS_EN
  ,
  output logic [15:0]          acc_cnt,
  output logic [7:0]           drop_cnt
`endif
);

  logic [LAT-1:0] vld_d;
  logic [n-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count_q;
  logic           overflow_q;

  logic push_req;
  logic push;
  logic pop;
  logic drop;
  logic full_w;
  logic empty_w;

  assign full_w   = (count_q == (AW+1)'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign push_req = vld_d[LAT-1];
  assign pop      = ~empty_w & bus.out_ready;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign push     = push_req & (~full_w | pop);
  assign drop     = push_req & ~push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d <= '0;
    end else begin
      vld_d[0] <= bus.in_valid;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] <= vld_d[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.f_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  // A drop in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef PIPE_RES_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push && acc_cnt != 16'hFFFF) begin
        acc_cnt <= acc_cnt + 16'd1;
      end
      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`endif

  assign bus.out_data  = empty_w ? '0 : mem[rd_ptr];
  assign bus.out_valid = ~empty_w;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pipeline_result_fifo.sv
// Self-checking bench for pipeline_result_fifo: directed vector table, hand sequences
// for reset and wrap, and randomized traffic checked against a queue-based reference model.
module tb_pipeline_result_fifo;

  localparam int n     = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [n-1:0] f_issue;
  logic [n-1:0] fpipe [LAT];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_result_fifo_if #(.n(n), .AW(AW)) bus ();

`ifdef PIPE_RES_STATS_EN
  logic [15:0] acc_cnt;
  logic [7:0]  drop_cnt;
`endif

  pipeline_result_fifo #(
    .n(n), .LAT(LAT), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef PIPE_RES_STATS_EN
    ,
    .acc_cnt (acc_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  // Stand-in for the upstream arithmetic pipeline: f appears LAT-1 edges after issue.
  always @(posedge clk) begin
    fpipe[0] <= f_issue;
    for (int i = 1; i < LAT; i++) begin
      fpipe[i] <= fpipe[i-1];
    end
  end
  assign bus.f_in = fpipe[LAT-1];

  logic [n-1:0] mq [$];
  bit           pend_v [$];
  logic [n-1:0] pend_f [$];
  bit           m_ovf;
  int           m_acc;
  int           m_drop;

  typedef struct {
    bit           iv;
    logic [n-1:0] f;
    bit           rdy;
    bit           clr;
    bit           ev;
    logic [n-1:0] ed;
    int           ec;
    bit           ef;
    bit           eo;
  } vec_t;

  vec_t tbl [28];

  function automatic logic [n-1:0] calc_f(input int a, input int b, input int c, input int d);
    int r;
    r = ((a + b) + (c - d)) * d;
    return n'(r);
  endfunction

  function automatic vec_t mk(input bit iv, input int f, input bit rdy, input bit clr,
                              input bit ev, input int ed, input int ec, input bit ef, input bit eo);
    vec_t v;
    v.iv = iv; v.f = n'(f); v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = n'(ed); v.ec = ec; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  task automatic modelReset();
    mq.delete();
    pend_v.delete();
    pend_f.delete();
    for (int i = 0; i < LAT; i++) begin
      pend_v.push_back(1'b0);
      pend_f.push_back('0);
    end
    m_ovf  = 1'b0;
    m_acc  = 0;
    m_drop = 0;
  endtask

  // One clock edge of the reference: the result issued LAT edges ago arrives now.
  task automatic modelEdge(input bit iv, input logic [n-1:0] f, input bit rdy, input bit clr);
    bit           pv;
    logic [n-1:0] pf;
    bit           do_pop;
    bit           do_push;
    pv = pend_v.pop_front();
    pf = pend_f.pop_front();
    pend_v.push_back(iv);
    pend_f.push_back(f);
    do_pop  = (mq.size() > 0) && rdy;
    do_push = pv && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(pf);
      if (m_acc < 65535) m_acc++;
    end
    if (pv && !do_push) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit iv, input logic [n-1:0] f, input bit rdy, input bit clr);
    bus.in_valid  = iv;
    f_issue       = f;
    bus.out_ready = rdy;
    bus.ovf_clr   = clr;
    @(posedge clk);
    if (!rst_n) modelReset();
    else        modelEdge(iv, f, rdy, clr);
    #1;
  endtask

  task automatic checkOutput(input string tag, input bit ev, input logic [n-1:0] ed,
                             input int ec, input bit ef, input bit eo);
    cmp({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
    if (ev) cmp({tag, " out_data"}, 32'(bus.out_data), 32'(ed));
    cmp({tag, " count"},    32'(bus.count),    32'(ec));
    cmp({tag, " full"},     32'(bus.full),     32'(ef));
    cmp({tag, " overflow"}, 32'(bus.overflow), 32'(eo));
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, mq.size() > 0, (mq.size() > 0) ? mq[0] : '0,
                mq.size(), mq.size() == DEPTH, m_ovf);
`ifdef PIPE_RES_STATS_EN
    cmp({tag, " acc_cnt"},  32'(acc_cnt),  32'(m_acc));
    cmp({tag, " drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  initial begin
    logic [n-1:0] seen [$];
    logic [n-1:0] rf;
    bit           rdy;
    int           rdy_pct;

    // Directed sequence: single result, burst to full, full with pop, overflow clear race.
    tbl[0]  = mk(1, int'(calc_f(2, 3, 9, 5)), 0, 0,  0,  0, 0, 0, 0);
    tbl[1]  = mk(0,  0, 0, 0,  0,  0, 0, 0, 0);
    tbl[2]  = mk(0,  0, 0, 0,  0,  0, 0, 0, 0);
    tbl[3]  = mk(0,  0, 0, 0,  1, 45, 1, 0, 0);
    tbl[4]  = mk(0,  0, 1, 0,  0,  0, 0, 0, 0);
    tbl[5]  = mk(1, 10, 0, 0,  0,  0, 0, 0, 0);
    tbl[6]  = mk(1, 20, 0, 0,  0,  0, 0, 0, 0);
    tbl[7]  = mk(1, 30, 0, 0,  0,  0, 0, 0, 0);
    tbl[8]  = mk(1, 40, 0, 0,  1, 10, 1, 0, 0);
    tbl[9]  = mk(1, 50, 0, 0,  1, 10, 2, 0, 0);
    tbl[10] = mk(1, 60, 0, 0,  1, 10, 3, 0, 0);
    tbl[11] = mk(0,  0, 0, 0,  1, 10, 4, 1, 0);
    tbl[12] = mk(0,  0, 0, 0,  1, 10, 4, 1, 1);
    tbl[13] = mk(0,  0, 1, 0,  1, 20, 4, 1, 1);
    tbl[14] = mk(0,  0, 1, 0,  1, 30, 3, 0, 1);
    tbl[15] = mk(0,  0, 1, 0,  1, 40, 2, 0, 1);
    tbl[16] = mk(0,  0, 1, 0,  1, 60, 1, 0, 1);
    tbl[17] = mk(0,  0, 1, 0,  0,  0, 0, 0, 1);
    tbl[18] = mk(1,  1, 0, 0,  0,  0, 0, 0, 1);
    tbl[19] = mk(1,  2, 0, 0,  0,  0, 0, 0, 1);
    tbl[20] = mk(1,  3, 0, 0,  0,  0, 0, 0, 1);
    tbl[21] = mk(1,  4, 0, 0,  1,  1, 1, 0, 1);
    tbl[22] = mk(1,  5, 0, 0,  1,  1, 2, 0, 1);
    tbl[23] = mk(0,  0, 0, 0,  1,  1, 3, 0, 1);
    tbl[24] = mk(0,  0, 0, 0,  1,  1, 4, 1, 1);
    tbl[25] = mk(0,  0, 0, 1,  1,  1, 4, 1, 1);
    tbl[26] = mk(0,  0, 0, 1,  1,  1, 4, 1, 0);
    tbl[27] = mk(0,  0, 1, 0,  1,  2, 3, 0, 0);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    f_issue       = '0;
    rst_n         = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, '0, 0, 0, 0);
    cmp("reset out_data", 32'(bus.out_data), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      applyStimulus(tbl[i].iv, tbl[i].f, tbl[i].rdy, tbl[i].clr);
      checkOutput($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].eo);
    end
`ifdef PIPE_RES_STATS_EN
    cmp("table acc_cnt",  32'(acc_cnt),  10);
    cmp("table drop_cnt", 32'(drop_cnt), 2);
`endif

    // Reset mid-flight: strobe at edge k, reset held across edge k+2, released before k+3.
    applyStimulus(1, 10'd77, 0, 0);
    applyStimulus(0, '0, 0, 0);
    rst_n = 1'b0;
    modelReset();
    applyStimulus(0, '0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 1, 0);
      checkOutput($sformatf("midrst%0d", i), 0, '0, 0, 0, 0);
    end

    // Pointer wrap: twelve back-to-back results drained continuously.
    for (int i = 0; i < 12 + LAT + 2; i++) begin
      applyStimulus(i < 12, n'(i + 1), 1, 0);
      checkModel($sformatf("wrap%0d", i));
      if (bus.count > 2) cmp($sformatf("wrap%0d count_max", i), 32'(bus.count), 2);
      if (bus.out_valid) seen.push_back(bus.out_data);
    end
    cmp("wrap seen_count", seen.size(), 12);
    for (int i = 0; i < 12 && i < seen.size(); i++) begin
      cmp($sformatf("wrap order%0d", i), 32'(seen[i]), i + 1);
    end

    // Randomized traffic with shifting consumer readiness.
    for (int i = 0; i < 600; i++) begin
      rdy_pct = (i < 200) ? 30 : (i < 400) ? 90 : 60;
      rf      = n'($urandom);
      rdy     = ($urandom_range(0, 99) < rdy_pct);
      applyStimulus($urandom_range(0, 1) == 1, rf, rdy, $urandom_range(0, 7) == 0);
      checkModel($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_result_fifo.md
Name: pipeline_result_fifo

Overview:
- Downstream consumer of the 3-stage arithmetic pipeline that produces f = ((a+b)+(c-d))*d.
- That pipeline carries no valid qualifier. This block re-creates one by delaying the operand-issue strobe by the pipeline latency.
- On each aligned strobe it captures f into a small FIFO and presents results to the next consumer over a valid/ready handshake.
- Results that arrive while the FIFO is full are dropped and flagged with a sticky overflow bit.

Parameters:
- n, 10, data width of f_in and out_data.
- LAT, 3, upstream pipeline latency in rising edges from operand sample to f stable. Range 1..8.
- DEPTH, 4, FIFO entries. Power of two, ≥2.
- AW, 2, log2(DEPTH). Must match DEPTH.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream pipeline.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  high in the cycle operands a,b,c,d are presented to the upstream pipeline.
- f_in  input  n  result bus from the upstream pipeline (its f output).
- out_data  output  n  FIFO head entry.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  AW+1  current FIFO occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: an aligned result was dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset, asynchronous on rst_n low:
  - valid delay line cleared.
  - FIFO read/write pointers and count = 0.
  - out_valid = 0, full = 0, overflow = 0.
  - out_data = 0 (storage array need not clear).
  - In-flight strobes are discarded. Operands issued before reset release never produce a push.
- Alignment:
  - LAT-deep shift register vld_d[LAT-1:0], fed by in_valid.
  - in_valid sampled at edge k asserts push_req = vld_d[LAT-1] during the cycle after edge k+LAT-1.
  - f_in is written at edge k+LAT.
  - Back-to-back in_valid yields back-to-back pushes. Gaps are preserved exactly.
- Push: push_req & (~full | pop).
- Pop: out_valid & out_ready.
- Empty FIFO:
  - No combinational bypass. A pushed value appears on out_data/out_valid the cycle after the write edge.
  - out_ready while empty is ignored. count stays 0 and there is no underflow.
- Full FIFO:
  - Simultaneous push and pop are both accepted. count stays DEPTH.
  - push_req while full with no pop drops the value, leaves the FIFO untouched, and sets overflow at that edge.
- Simultaneous push/pop when neither empty nor full: count unchanged, both pointers advance.
- Pointers are AW bits and wrap modulo DEPTH. count is derived from separate up/down logic.
- overflow:
  - Cleared by ovf_clr at the next edge.
  - If ovf_clr and a new drop occur in the same cycle, overflow stays 1 (set wins).
- out_data is registered head data, or array read at rd_ptr. It must be stable while out_valid=1 and out_ready=0.
- Data path is pass-through with no width change. f_in is already truncated to n bits upstream.

Optional Feature:
- Macro: PIPE_RES_STATS_EN.
- Defined:
  - Adds output port acc_cnt[15:0]: number of results successfully pushed since reset. Increments on push. Saturates at 16'hFFFF. Reset to 0.
  - Adds output port drop_cnt[7:0]: number of dropped results. Saturates at 8'hFF. Reset to 0.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Single result:
  - Stimulus: reset, then in_valid=1 for one cycle with a=2,b=3,c=9,d=5. Bench model drives f_in=45 from LAT=3 edges onward.
  - Response: out_valid rises one cycle after edge k+3; out_data=45; count=1; a pop returns count=0.
- Burst to full:
  - Stimulus: out_ready=0; 5 consecutive in_valid with f_in sequence 10,20,30,40,50.
  - Response: FIFO holds 10,20,30,40; full=1; 50 dropped; overflow=1. With PIPE_RES_STATS_EN: acc_cnt=4, drop_cnt=1.
- Full with pop:
  - Stimulus: FIFO full (10..40); aligned push of 60 in the same cycle as out_ready=1.
  - Response: 10 popped, 60 accepted; count stays 4; overflow unchanged; drain order 20,30,40,60.
- Pointer wrap:
  - Stimulus: 12 results 1..12 with out_ready=1 continuously.
  - Response: out_data sequence 1..12 in order; count never exceeds 2; no overflow.
- Reset mid-flight:
  - Stimulus: in_valid at edge k; rst_n low between edges k+1 and k+2, released before k+3.
  - Response: no push occurs; out_valid=0; count=0.
- Overflow clear race:
  - Stimulus: overflow=1; ovf_clr=1 in the same cycle as a drop.
  - Response: overflow remains 1. A later ovf_clr with no drop gives overflow=0.
